// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester byte streams and uart_tx strobe bundle.
// master drives requests and tx_ready; slave is the arbiter.
interface uart_tx_arbiter_if #(
  parameter int N = 2
);
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ack;
  logic [N-1:0]   grant;
  logic [7:0]     tx_data;
  logic           tx_strobe;
  logic           tx_ready;
  logic           timeout;

  modport master (
    output req_valid, req_data, req_last, tx_ready,
    input  req_ack, grant, tx_data, tx_strobe, timeout
  );

  modport slave (
    input  req_valid, req_data, req_last, tx_ready,
    output req_ack, grant, tx_data, tx_strobe, timeout
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: packet-atomic round-robin share of one uart_tx.
// Grants drop on last byte, burst cap or stall timeout.
module uart_tx_arbiter #(
  parameter int N         = 2,
  parameter int TIMEOUT   = 4096,
  parameter int MAX_BURST = 256,
  parameter int CNT_W     = 16
) (
  input logic             clk,
  input logic             reset,
  uart_tx_arbiter_if.slave bus
);
  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] TO_LAST =
    CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] BURST_LAST =
    CNT_W'(MAX_BURST - 1);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    owner_q, owner_d;
  logic [PW-1:0]    rr_q, rr_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] burst_q, burst_d;
  logic [N-1:0]     grant_q, grant_d;
  logic [N-1:0]     ack_q, ack_d;
  logic [7:0]       data_q, data_d;
  logic             strobe_q, strobe_d;
  logic             to_q, to_d;

  logic             own_valid;
  logic             own_last;
  logic [7:0]       own_byte;
  logic             send;
  logic             burst_end;
  logic             stall_end;
  logic [PW-1:0]    rr_next;
  logic             pick_found;
  logic [PW-1:0]    pick_idx;
  logic [PW:0]      cand;

  assign own_valid = bus.req_valid[owner_q];
  assign own_last  = bus.req_last[owner_q];
  assign own_byte  = bus.req_data[{owner_q, 3'b000} +: 8];
  assign send      = own_valid && bus.tx_ready && !strobe_q;
  assign burst_end = (MAX_BURST != 0) && (burst_q == BURST_LAST);
  assign stall_end = (TIMEOUT != 0) && (stall_q == TO_LAST);
  assign rr_next   = (owner_q == PW'(N - 1)) ? '0
                   : owner_q + 1'b1;

  // first valid requester at or after rr_q, wrapping
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = 0; k < N; k++) begin
      cand = {1'b0, rr_q} + (PW+1)'(k);
      if (cand >= (PW+1)'(N))
        cand = cand - (PW+1)'(N);
      if (!pick_found && bus.req_valid[cand[PW-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = cand[PW-1:0];
      end
    end
  end

  // next state and registered outputs
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_d     = rr_q;
    stall_d  = stall_q;
    burst_d  = burst_q;
    grant_d  = grant_q;
    ack_d    = '0;
    data_d   = data_q;
    strobe_d = 1'b0;
    to_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d = GRANT;
          owner_d = pick_idx;
          grant_d = {{(N-1){1'b0}}, 1'b1} << pick_idx;
          stall_d = '0;
          burst_d = '0;
        end
      end
      GRANT: begin
        if (send) begin
          data_d   = own_byte;
          strobe_d = 1'b1;
          ack_d    = grant_q;
          burst_d  = burst_q + 1'b1;
          stall_d  = '0;
          if (own_last || burst_end) begin
            state_d = IDLE;
            grant_d = '0;
            rr_d    = rr_next;
          end
        end else if (!own_valid) begin
          if (stall_end) begin
            state_d = IDLE;
            grant_d = '0;
            rr_d    = rr_next;
            to_d    = 1'b1;
          end else begin
            stall_d = stall_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // state and output registers, synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      rr_q     <= '0;
      stall_q  <= '0;
      burst_q  <= '0;
      grant_q  <= '0;
      ack_q    <= '0;
      data_q   <= '0;
      strobe_q <= 1'b0;
      to_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_q     <= rr_d;
      stall_q  <= stall_d;
      burst_q  <= burst_d;
      grant_q  <= grant_d;
      ack_q    <= ack_d;
      data_q   <= data_d;
      strobe_q <= strobe_d;
      to_q     <= to_d;
    end
  end

  assign bus.req_ack   = ack_q;
  assign bus.grant     = grant_q;
  assign bus.tx_data   = data_q;
  assign bus.tx_strobe = strobe_q;
  assign bus.timeout   = to_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed and random requester traffic
// against a transaction-level reference of the arbiter.
module tb_uart_tx_arbiter;
  localparam int N  = 3;
  localparam int TO = 8;
  localparam int MB = 4;

  typedef struct {
    logic [7:0] b;
    bit         last;
    int         gap;
  } ent_t;

  logic clk;
  logic reset;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.N(N)) bus ();

  uart_tx_arbiter #(
    .N(N), .TIMEOUT(TO), .MAX_BURST(MB), .CNT_W(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave)
  );

  ent_t       q[N][$];
  int         gap_left[N];
  bit         loaded[N];
  logic [N-1:0] v;
  logic [N-1:0] l;
  logic [7:0] d[N];
  logic       rdy;
  int         rdy_mode;

  int         m_owner;
  int         m_ptr;
  int         m_stall;
  int         m_burst;
  bit         m_strobe;
  bit         m_to;
  logic [7:0] m_data;
  logic [N-1:0] m_ack;

  int         checks;
  int         errors;
  int         to_seen;
  int         log_src[$];
  logic [7:0] log_byte[$];

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [N-1:0] onehot(int i);
    logic [N-1:0] r;
    r = '0;
    if (i >= 0) r[i] = 1'b1;
    return r;
  endfunction

  function automatic int src_of(logic [N-1:0] a);
    for (int i = 0; i < N; i++)
      if (a[i]) return i;
    return -1;
  endfunction

  function automatic int pending();
    int n;
    n = (m_owner >= 0) ? 1 : 0;
    for (int i = 0; i < N; i++) n += q[i].size();
    return n;
  endfunction

  // reference: grant owner, pointer and counters as plain integers
  task automatic model_step();
    bit prev;
    int g;
    int idx;
    if (reset) begin
      m_owner = -1; m_ptr = 0; m_stall = 0; m_burst = 0;
      m_strobe = 0; m_to = 0; m_data = '0; m_ack = '0;
      return;
    end
    prev = m_strobe;
    m_strobe = 0; m_to = 0; m_ack = '0;
    if (m_owner < 0) begin
      for (int k = 0; k < N; k++) begin
        idx = (m_ptr + k) % N;
        if (v[idx]) begin
          m_owner = idx; m_stall = 0; m_burst = 0;
          break;
        end
      end
    end else begin
      g = m_owner;
      if (v[g] && rdy && !prev) begin
        m_data = d[g]; m_strobe = 1; m_ack[g] = 1'b1;
        m_burst++; m_stall = 0;
        if (l[g] || m_burst == MB) begin
          m_owner = -1; m_ptr = (g + 1) % N;
        end
      end else if (!v[g]) begin
        m_stall++;
        if (m_stall == TO) begin
          m_owner = -1; m_ptr = (g + 1) % N; m_to = 1;
        end
      end
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (q[i].size() > 0 && !loaded[i]) begin
        gap_left[i] = q[i][0].gap;
        loaded[i] = 1;
      end
      if (q[i].size() > 0 && gap_left[i] == 0) begin
        v[i] = 1'b1; d[i] = q[i][0].b; l[i] = q[i][0].last;
      end else begin
        v[i] = 1'b0; d[i] = 8'($urandom); l[i] = 1'($urandom);
        if (gap_left[i] > 0) gap_left[i]--;
      end
      bus.req_data[i*8 +: 8] = d[i];
    end
    case (rdy_mode)
      0: rdy = 1'b1;
      1: rdy = 1'b0;
      default: rdy = ($urandom_range(0, 3) != 0);
    endcase
    bus.req_valid = v;
    bus.req_last  = l;
    bus.tx_ready  = rdy;
  endtask

  task automatic step();
    drive();
    model_step();
    @(posedge clk);
    #1;
    chk("grant", 32'(bus.grant), 32'(onehot(m_owner)));
    chk("tx_strobe", 32'(bus.tx_strobe), 32'(m_strobe));
    chk("req_ack", 32'(bus.req_ack), 32'(m_ack));
    chk("timeout", 32'(bus.timeout), 32'(m_to));
    if (m_strobe)
      chk("tx_data", 32'(bus.tx_data), 32'(m_data));
    if (bus.tx_strobe) begin
      log_byte.push_back(bus.tx_data);
      log_src.push_back(src_of(bus.req_ack));
    end
    if (bus.timeout) to_seen++;
    for (int i = 0; i < N; i++)
      if (m_ack[i] && q[i].size() > 0) begin
        void'(q[i].pop_front());
        loaded[i] = 0;
      end
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < N; i++) begin
      q[i].delete(); loaded[i] = 0; gap_left[i] = 0;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_reqs();
    step();
    step();
    reset = 1'b0;
    log_byte.delete();
    log_src.delete();
    to_seen = 0;
  endtask

  task automatic drain(string tag, int max);
    int n;
    n = 0;
    while (pending() != 0 && n < max) begin
      step(); n++;
    end
    chk(tag, 32'(pending()), 32'd0);
  endtask

  task automatic push(int i, logic [7:0] b, bit last, int gap);
    ent_t e;
    e.b = b; e.last = last; e.gap = gap;
    q[i].push_back(e);
  endtask

  initial begin
    int n;
    checks = 0; errors = 0; to_seen = 0; rdy_mode = 0;
    v = '0; l = '0; rdy = 1'b1;
    m_strobe = 0;
    bus.req_valid = '0; bus.req_data = '0;
    bus.req_last = '0; bus.tx_ready = 1'b1;

    // reset state
    do_reset();
    chk("rst_grant", 32'(bus.grant), 32'd0);
    chk("rst_strobe", 32'(bus.tx_strobe), 32'd0);
    chk("rst_data", 32'(bus.tx_data), 32'd0);

    // single packet from req 0
    push(0, 8'h41, 0, 0); push(0, 8'h42, 0, 0);
    push(0, 8'h43, 1, 0);
    drain("pkt_drain", 100);
    chk("pkt_len", 32'(log_byte.size()), 32'd3);
    chk("pkt_b0", 32'(log_byte[0]), 32'h41);
    chk("pkt_b2", 32'(log_byte[2]), 32'h43);
    chk("pkt_src", 32'(log_src[1]), 32'd0);
    // rr pointer moved past 0: req 1 wins next
    push(0, 8'h55, 1, 0); push(1, 8'h66, 1, 0);
    drain("rr_drain", 100);
    chk("rr_first", 32'(log_src[3]), 32'd1);
    chk("rr_second", 32'(log_src[4]), 32'd0);

    // two requesters alternating single-byte packets
    do_reset();
    for (int k = 0; k < 3; k++) begin
      push(0, 8'hA0, 1, 0); push(1, 8'hB1, 1, 0);
    end
    drain("alt_drain", 200);
    chk("alt_b0", 32'(log_byte[0]), 32'hA0);
    chk("alt_b1", 32'(log_byte[1]), 32'hB1);
    chk("alt_b2", 32'(log_byte[2]), 32'hA0);
    chk("alt_len", 32'(log_byte.size()), 32'd6);

    // fairness over all three requesters
    do_reset();
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < N; i++) push(i, 8'hC0 + 8'(i), 1, 0);
    drain("fair_drain", 200);
    chk("fair_2", 32'(log_src[2]), 32'd2);
    chk("fair_3", 32'(log_src[3]), 32'd0);

    // req 1 mid-packet keeps the grant against req 0
    do_reset();
    for (int k = 0; k < 4; k++) push(1, 8'h30 + 8'(k), k == 3, 0);
    n = 0;
    while (log_byte.size() < 2 && n < 50) begin
      step(); n++;
    end
    chk("mid_wait", 32'(log_byte.size()), 32'd2);
    push(0, 8'h50, 1, 0);
    drain("mid_drain", 100);
    chk("mid_src3", 32'(log_src[3]), 32'd1);
    chk("mid_src4", 32'(log_src[4]), 32'd0);
    chk("mid_b4", 32'(log_byte[4]), 32'h50);

    // stall timeout hands over to waiting req 1
    do_reset();
    push(0, 8'h10, 0, 0); push(0, 8'h11, 1, 20);
    push(1, 8'h20, 1, 2);
    drain("to_drain", 200);
    chk("to_count", 32'(to_seen), 32'd1);
    chk("to_src1", 32'(log_src[1]), 32'd1);
    chk("to_b2", 32'(log_byte[2]), 32'h11);

    // burst cap forces release after 4 bytes
    do_reset();
    for (int k = 0; k < 10; k++) push(0, 8'h60 + 8'(k), 0, 0);
    push(1, 8'h70, 1, 0);
    drain("burst_drain", 300);
    chk("burst_b3", 32'(log_byte[3]), 32'h63);
    chk("burst_b4", 32'(log_byte[4]), 32'h70);
    chk("burst_b5", 32'(log_byte[5]), 32'h64);

    // tx_ready low is not a stall, then reset mid-packet
    do_reset();
    rdy_mode = 1;
    push(0, 8'h80, 0, 0); push(0, 8'h81, 0, 0);
    push(0, 8'h82, 1, 0);
    for (int k = 0; k < 100; k++) step();
    chk("hold_strobes", 32'(log_byte.size()), 32'd0);
    chk("hold_timeouts", 32'(to_seen), 32'd0);
    chk("hold_grant", 32'(bus.grant), 32'd1);
    rdy_mode = 0;
    n = 0;
    while (log_byte.size() < 1 && n < 20) begin
      step(); n++;
    end
    chk("rstmid_wait", 32'(log_byte.size()), 32'd1);
    reset = 1'b1;
    clear_reqs();
    step();
    chk("rstmid_grant", 32'(bus.grant), 32'd0);
    chk("rstmid_strobe", 32'(bus.tx_strobe), 32'd0);
    chk("rstmid_ack", 32'(bus.req_ack), 32'd0);
    chk("rstmid_data", 32'(bus.tx_data), 32'd0);
    reset = 1'b0;

    // random traffic against the reference
    do_reset();
    rdy_mode = 2;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++)
        if (q[i].size() < 3 && $urandom_range(0, 3) == 0) begin
          int len;
          len = $urandom_range(1, 5);
          for (int k = 0; k < len; k++)
            push(i, 8'($urandom), k == len - 1,
                 ($urandom_range(0, 24) == 0) ? 12
                 : $urandom_range(0, 2));
        end
      step();
    end
    drain("rand_drain", 3000);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
